// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin mining datapath blocks (nonce_select,
// bitcoin_hash): scan length default, scan FSM states, result record layout.
package bitcoin_pkg;

  // Default number of consecutive hash words examined per scan.
  localparam int NUM_NONCES_DEFAULT = 16;

  // Scan controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Word offsets inside the 3-word result record.
  localparam logic [15:0] RES_OFS_NONCE = 16'd0;
  localparam logic [15:0] RES_OFS_MIN   = 16'd1;
  localparam logic [15:0] RES_OFS_FOUND = 16'd2;

  // "Nothing found yet" values for the scan statistics.
  localparam logic [7:0]  NONCE_NONE = 8'hFF;
  localparam logic [31:0] HASH_MAX   = 32'hFFFF_FFFF;

endpackage

// File: rtl/nonce_select.sv
// Scans NUM_NONCES consecutive hash words from memory, tracks the smallest
// hash and the first nonce whose hash is below target, and writes a 3-word
// result record {best_nonce, min_hash, found} back to memory.
module nonce_select
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] min_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // rd_idx counts up to NUM_NONCES itself, so it needs one bit beyond 8.
  localparam logic [8:0] LAST_IDX = 9'(NUM_NONCES - 1);

  state_t      state;
  logic [8:0]  rd_idx;
  logic [1:0]  wr_cnt;
  logic [15:0] hash_base;
  logic [15:0] res_base;
  logic [31:0] target_q;

  logic        cmp_valid;
  logic [7:0]  cmp_idx;
  logic        found_n;
  logic [7:0]  best_n;
  logic [31:0] min_n;

  assign mem_clk = clk;
  assign done    = (state == IDLE);

  // Compare the word returned for the previous address against the running
  // minimum and the target; produces next-state statistics.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    cmp_valid = ((state == READ) && (rd_idx != 9'd0)) || (state == DRAIN);
    cmp_idx   = 8'(rd_idx - 9'd1);
    found_n   = found;
    best_n    = best_nonce;
    min_n     = min_hash;
    if (cmp_valid) begin
      if (mem_read_data < min_hash) min_n = mem_read_data;
      if (!found && (mem_read_data < target_q)) begin
        found_n = 1'b1;
        best_n  = cmp_idx;
      end
    end
  end

  // Scan FSM, address generation, statistics and result write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rd_idx         <= '0;
      wr_cnt         <= '0;
      hash_base      <= '0;
      res_base       <= '0;
      target_q       <= '0;
      found          <= 1'b0;
      best_nonce     <= NONCE_NONE;
      min_hash       <= HASH_MAX;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // statement in this block sees the pre-edge values.
      found      <= found_n;
      best_nonce <= best_n;
      min_hash   <= min_n;
      unique case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (start) begin
            hash_base  <= hash_addr;
            res_base   <= result_addr;
            target_q   <= target;
            found      <= 1'b0;
            best_nonce <= NONCE_NONE;
            min_hash   <= HASH_MAX;
            rd_idx     <= '0;
            mem_addr   <= hash_addr;
            state      <= READ;
          end
        end
        READ: begin
          rd_idx <= rd_idx + 9'd1;
          if (rd_idx == LAST_IDX) state <= DRAIN;
          else mem_addr <= hash_base + 16'(rd_idx + 9'd1);
        end
        DRAIN: begin
          // The final word is compared this cycle, so the record's first word
          // must use the freshly computed best nonce.
          mem_we         <= 1'b1;
          mem_addr       <= res_base + RES_OFS_NONCE;
          mem_write_data <= {24'b0, best_n};
          wr_cnt         <= '0;
          state          <= WRITE;
        end
        WRITE: begin
          wr_cnt <= wr_cnt + 2'd1;
          unique case (wr_cnt)
            2'd0: begin
              mem_addr       <= res_base + RES_OFS_MIN;
              mem_write_data <= min_hash;
            end
            2'd1: begin
              mem_addr       <= res_base + RES_OFS_FOUND;
              mem_write_data <= {31'b0, found};
            end
            default: begin
              mem_we <= 1'b0;
              state  <= IDLE;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_select.sv
// Self-checking bench for nonce_select: synchronous-read memory model, a
// reference model of the scan, and a scoreboard of expected result writes.
module tb_nonce_select;
  localparam int N = 16;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] hash_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [7:0]  best_nonce;
  logic [31:0] min_hash;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  logic [31:0] hv [N];
  wr_t         sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_seen = 0;

  nonce_select #(.NUM_NONCES(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .hash_addr      (hash_addr),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .best_nonce     (best_nonce),
    .min_hash       (min_hash),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; the bench preloads through the bd_* port.
  always @(posedge mem_clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every result-record write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_seen++;
      if (sb.size() == 0) begin
        check("sb_nonempty_on_write", 32'(sb.size()), 32'd1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_write_data, e.data);
      end
    end
  end

  task automatic load_hashes(input logic [15:0] ha);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = ha + 16'(k);
      bd_data = hv[k];
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic model(input logic [31:0] tg, output logic f, output logic [7:0] b,
                       output logic [31:0] m);
    f = 1'b0;
    b = 8'hFF;
    m = 32'hFFFF_FFFF;
    for (int k = 0; k < N; k++) begin
      if (hv[k] < m) m = hv[k];
      if (!f && hv[k] < tg) begin
        f = 1'b1;
        b = 8'(k);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_write_data, 32'd0);
    check({tag, "_found"}, 32'(found), 32'd0);
    check({tag, "_best"},  32'(best_nonce), 32'h0000_00FF);
    check({tag, "_min"},   min_hash, 32'hFFFF_FFFF);
  endtask

  // One scan: optional start pulse at cycle pulse_at, optional reset at
  // cycle reset_at (cycle 1 is the first cycle after the start edge).
  task automatic run_scan(input string name, input logic [15:0] ha, input logic [15:0] ra,
                          input logic [31:0] tg, input int pulse_at, input int reset_at);
    logic        f;
    logic [7:0]  b;
    logic [31:0] m;
    int          cyc;
    bit          fin;
    load_hashes(ha);
    model(tg, f, b, m);
    sb.push_back('{ra + 16'd0, {24'b0, b}});
    sb.push_back('{ra + 16'd1, m});
    sb.push_back('{ra + 16'd2, {31'b0, f}});
    wr_seen = 0;
    @(negedge clk);
    hash_addr   = ha;
    result_addr = ra;
    target      = tg;
    start       = 1'b1;
    reset       = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_busy"}, 32'(done), 32'd0);
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == pulse_at) begin
        start     = 1'b1;
        hash_addr = ha ^ 16'h0100;
        target    = 32'h0;
      end else begin
        start     = 1'b0;
        hash_addr = ha;
        target    = tg;
      end
      if (cyc == reset_at) begin
        reset = 1'b1;
        #1 check_reset_state({name, "_rst"});
        sb.delete();
        fin = 1'b1;
      end else if (done) begin
        fin = 1'b1;
      end
    end
    start = 1'b0;
    if (reset_at > 0) begin
      repeat (3) @(posedge clk);
      #1 check({name, "_writes"}, 32'(wr_seen), (reset_at > N) ? 32'd1 : 32'd0);
      check_reset_state({name, "_hold"});
    end else begin
      check({name, "_cycles"}, 32'(cyc), 32'(N + 4));
      check({name, "_found"}, 32'(found), 32'(f));
      check({name, "_best"}, 32'(best_nonce), 32'(b));
      check({name, "_min"}, min_hash, m);
      repeat (3) @(posedge clk);
      #1 check({name, "_writes"}, 32'(wr_seen), 32'd3);
      check({name, "_sb_left"}, 32'(sb.size()), 32'd0);
      check({name, "_stable_min"}, min_hash, m);
      check({name, "_rec0"}, mem[ra], {24'b0, b});
      check({name, "_rec1"}, mem[ra + 16'd1], m);
      check({name, "_rec2"}, mem[ra + 16'd2], {31'b0, f});
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    hash_addr   = '0;
    result_addr = '0;
    target      = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_state("por");

    for (int k = 0; k < N; k++) hv[k] = 32'h9000_0000 + 32'(k);
    run_scan("ascend", 16'h1000, 16'h2000, 32'h9000_0005, 0, 0);

    for (int k = 0; k < N; k++) hv[k] = 32'hFFFF_FFF0;
    run_scan("none", 16'h1100, 16'h2010, 32'h1000_0000, 0, 0);

    for (int k = 0; k < N; k++) hv[k] = 32'h8000_0000;
    hv[7]  = 32'h0000_0010;
    hv[11] = 32'h0000_0010;
    run_scan("first7", 16'h1200, 16'h2020, 32'h0000_0020, 0, 0);
    hv[7] = 32'h0000_0020;
    run_scan("eq_tgt", 16'h1200, 16'h2030, 32'h0000_0020, 0, 0);

    for (int k = 0; k < N; k++) hv[k] = 32'h7000_0000 - 32'(k * 3);
    run_scan("wrap", 16'hFFF8, 16'h3000, 32'h6FFF_FFF0, 0, 0);

    for (int k = 0; k < N; k++) hv[k] = 32'h0;
    run_scan("tgt0", 16'h1300, 16'h2040, 32'h0, 0, 0);

    for (int k = 0; k < N; k++) hv[k] = 32'h5000_0000 + 32'((N - k) * 16);
    run_scan("pulse", 16'h1400, 16'h2050, 32'h5000_0080, 3, 0);
    run_scan("rst_read", 16'h1400, 16'h2060, 32'h5000_0080, 0, 5);
    run_scan("after_rr", 16'h1400, 16'h2070, 32'h5000_0080, 0, 0);
    run_scan("rst_write", 16'h1400, 16'h2080, 32'h5000_0080, 0, N + 2);
    check("rst_write_rec1_untouched", mem[16'h2081], 32'h0);
    run_scan("after_rw", 16'h1400, 16'h2090, 32'h5000_0080, 0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) hv[k] = $urandom();
      run_scan("rand", 16'h4000 + 16'(r * 32), 16'h5000 + 16'(r * 4), $urandom(), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nonce_select.md
NONCE_SELECT -- requirements
Module: nonce_select

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16, number of consecutive hash words to scan (1..256).
REQ-002 SHALL have port clk  input  1  single clock for all logic and memory.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin a scan when sampled high in IDLE.
REQ-005 SHALL have port hash_addr  input  16  word address of hash word for nonce 0.
REQ-006 SHALL have port result_addr  input  16  word address of the 3-word result record.
REQ-007 SHALL have port target  input  32  difficulty threshold, unsigned.
REQ-008 SHALL have port done  output  1  high exactly while in IDLE.
REQ-009 SHALL have port found  output  1  last scan had at least one hash below target.
REQ-010 SHALL have port best_nonce  output  8  lowest nonce index whose hash is below target.
REQ-011 SHALL have port min_hash  output  32  smallest hash word seen in last scan.
REQ-012 SHALL have ports mem_clk  output  1 (equals clk), mem_we  output  1, mem_addr  output  16, mem_write_data  output  32, mem_read_data  input  32.

Function
REQ-013 SHALL implement states IDLE, READ, DRAIN, WRITE; enum in package.
REQ-014 SHALL, in IDLE with start=1, latch hash_addr, result_addr, target; clear found to 0, best_nonce to 8'hFF, min_hash to 32'hFFFFFFFF; enter READ with rd_idx=0.
REQ-015 SHALL ignore start in every state other than IDLE.
REQ-016 SHALL, in READ, drive mem_addr = latched hash_addr + rd_idx, mem_we=0, increment rd_idx each cycle, and move to DRAIN after issuing rd_idx = NUM_NONCES-1.
REQ-017 SHALL treat memory read latency as one cycle: the word for index k is on mem_read_data in the cycle after its address, and is compared in that cycle (READ cycles k+1 or DRAIN).
REQ-018 SHALL update min_hash when word < min_hash (strict, unsigned), so ties keep the earlier value.
REQ-019 SHALL, for the first word with word < target (strict, unsigned), set found=1 and best_nonce=k; later qualifying words SHALL NOT change best_nonce.
REQ-020 SHALL spend exactly one DRAIN cycle comparing the final word, then enter WRITE.
REQ-021 SHALL, in WRITE, assert mem_we for exactly 3 consecutive cycles writing result_addr+0 = {24'b0,best_nonce}, result_addr+1 = min_hash, result_addr+2 = {31'b0,found}, then return to IDLE.
REQ-022 SHALL return done high on the (NUM_NONCES+4)th rising edge after the edge sampling start (20 cycles for NUM_NONCES=16).
REQ-023 SHALL compute mem_addr as 16-bit sums with wrap-around modulo 2^16, no error flag.
REQ-024 SHALL hold found, best_nonce, min_hash stable from WRITE exit until the next accepted start.
REQ-025 SHALL report found=0, best_nonce=8'hFF when no word is below target, including target=0.

Reset
REQ-026 SHALL, on reset asserted at any time including mid-scan or mid-write, immediately set state=IDLE, mem_we=0, mem_addr=0, mem_write_data=0, found=0, best_nonce=8'hFF, min_hash=32'hFFFFFFFF, rd_idx=0.
REQ-027 SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL take NUM_NONCES default, state enum, and result-record offsets (0,1,2) from shared package bitcoin_pkg, also imported by bitcoin_hash.
REQ-029 SHALL be a single module with no sub-module; the compare/min logic is inline.
REQ-030 SHALL contain all registers in one always_ff block sensitive to posedge clk and posedge reset.

Verification
REQ-031 Hashes 0x90000000..0x9000000F, target 0x90000005 -> found=1, best_nonce=0, min_hash=0x90000000, done after 20 cycles.
REQ-032 All hashes 0xFFFFFFF0, target 0x10000000 -> found=0, best_nonce=0xFF, min_hash=0xFFFFFFF0; memory words result_addr+0..2 = 0x000000FF, 0xFFFFFFF0, 0.
REQ-033 Hash[7]=hash[11]=0x00000010, others 0x80000000, target 0x00000020 -> best_nonce=7, min_hash=0x00000010; hash[7]=target exactly -> best_nonce=11.
REQ-034 hash_addr=0xFFF8 -> reads wrap to 0x0000..0x0007; results correct.
REQ-035 Assert reset in READ cycle 5 and in second WRITE cycle -> done=1, mem_we=0 immediately; no further writes; next start gives correct results.
REQ-036 Pulse start during READ -> ignored; exactly one 3-word write burst observed.
